e_mdu: RTL
==========

E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high; sampled on the rising edge of clk.
REQ-003 SHALL have port MDUOp, input, 4 bits: E-stage op; 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-004 SHALL have port A, input, 32 bits: forwarded rs operand.
REQ-005 SHALL have port B, input, 32 bits: forwarded rt operand.
REQ-006 SHALL have port start, output, 1 bit: combinational; 1 when MDUOp is 1-4 and busy is 0.
REQ-007 SHALL have port busy, output, 1 bit: registered; 1 while an operation is in flight.
REQ-008 SHALL have port out, output, 32 bits: combinational; HI when MDUOp is 7, LO when MDUOp is 8, otherwise 0.

Function
REQ-009 SHALL hold 32-bit HI and LO registers, a 4-bit down-counter and 64-bit pending-result registers, with states IDLE (busy=0) and BUSY (busy=1).
REQ-010 SHALL handle start=1 in cycle N as follows: capture the result at the edge ending cycle N, load the counter with 5 (mult/multu) or 10 (div/divu), and go to BUSY.
REQ-011 SHALL decrement the counter on each edge while in BUSY.
REQ-012 SHALL, at the edge where the counter equals 1, commit the pending result to HI/LO, clear busy and return to IDLE.
REQ-013 SHALL hold busy=1 for exactly 5 cycles for mult/multu and exactly 10 cycles for div/divu.
REQ-014 SHALL make the committed HI/LO visible to mfhi/mflo in the first cycle after busy falls.
REQ-015 SHALL compute mult as signed A*B and multu as unsigned A*B, with HI = product[63:32] and LO = product[31:0].
REQ-016 SHALL compute div as a signed divide (LO = quotient, HI = remainder), truncating toward zero with the remainder taking the sign of the dividend; divu is the unsigned equivalent.
REQ-017 SHALL, for div/divu with B=0, still run the full busy period but leave HI and LO unchanged at commit.
REQ-018 SHALL, in IDLE, write mthi (A to HI) and mtlo (A to LO) at the edge ending the cycle the op is presented.
REQ-019 SHALL ignore ops 1-6 presented while busy=1: no state change and start=0; the hazard unit is responsible for stalling them.
REQ-020 SHALL, for mfhi/mflo presented while busy=1, return the current pre-commit HI/LO.
REQ-021 SHALL treat MDUOp=0, which is the flushed bubble inserted by a stall, as a no-op in every state.

Reset
REQ-022 SHALL, when reset=1 at an edge, clear HI, LO, the counter, the pending registers and busy, and enter IDLE.
REQ-023 SHALL let reset take priority over every op and over a pending commit, so an aborted operation never reaches HI/LO.
REQ-024 SHALL have reset values busy=0 and out=0; start depends only on MDUOp.

Configuration
REQ-025 SHALL use the macro MDU_DELAY_EN to select between two behaviours.
REQ-026 SHALL, with MDU_DELAY_EN defined, implement the multi-cycle behaviour of REQ-010 to REQ-014.
REQ-027 SHALL, with MDU_DELAY_EN undefined, write HI/LO directly at the edge ending the start cycle, tie busy to 0 and remove the counter; start, the op semantics and reset behaviour are unchanged.

Verification
REQ-028 SHALL cover: mult A=0xFFFFFFFF, B=2 -> busy=1 for 5 cycles; then mfhi=0xFFFFFFFF and mflo=0xFFFFFFFE.
REQ-029 SHALL cover: multu A=0xFFFFFFFF, B=2 -> mfhi=0x00000001 and mflo=0xFFFFFFFE; an mflo issued during busy returns the old LO.
REQ-030 SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> busy=1 for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-031 SHALL cover: mthi 0x12345678 then div B=0 -> after 10 busy cycles HI=0x12345678 and LO is unchanged.
REQ-032 SHALL cover: mult started, reset asserted in busy cycle 3 -> next cycle busy=0, HI=LO=0, and no later commit occurs.
REQ-033 SHALL cover: mtlo and mult presented during busy -> both ignored and start=0; with MDU_DELAY_EN undefined, mult 3*4 -> LO=12 in the next cycle and busy stays 0.

Source files
------------

// File: rtl/e_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : e_mdu                                                        |
// | Description : E-stage multiply/divide unit with HI/LO registers.           |
// |               MDU_DELAY_EN selects multi-cycle busy timing; otherwise      |
// |               results are written in the start cycle.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] out
);
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               w_is_div;
    logic               w_write;
    logic [63:0]        w_result;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic [31:0]        w_uquo;
    logic [31:0]        w_urem;

    assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_umul = {32'd0, A} * {32'd0, B};
    assign w_squo = $signed(A) / $signed(B);
    assign w_srem = $signed(A) % $signed(B);
    assign w_uquo = A / B;
    assign w_urem = A % B;

    always_comb begin
        w_result = 64'd0;
        case (MDUOp)
            c_OP_MULT:  w_result = w_smul;
            c_OP_MULTU: w_result = w_umul;
            c_OP_DIV:   w_result = {w_srem, w_squo};
            c_OP_DIVU:  w_result = {w_urem, w_uquo};
            default:    w_result = 64'd0;
        endcase
    end

    assign w_is_div = (MDUOp == c_OP_DIV) || (MDUOp == c_OP_DIVU);
    assign start    = (MDUOp >= c_OP_MULT) && (MDUOp <= c_OP_DIVU) && !busy;
    // A zero divisor still occupies the unit but must not disturb HI/LO.
    assign w_write  = start && !(w_is_div && (B == 32'd0));

    always_comb begin
        out = 32'd0;
        if (MDUOp == c_OP_MFHI) out = r_hi;
        else if (MDUOp == c_OP_MFLO) out = r_lo;
    end

`ifdef MDU_DELAY_EN
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_pend;
    logic        r_pend_we;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_BUSY;
            S_BUSY:  if (r_cnt == 4'd1) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_cnt     <= 4'd0;
            r_pend    <= 64'd0;
            r_pend_we <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (MDUOp == c_OP_MTHI) r_hi <= A;
            if (MDUOp == c_OP_MTLO) r_lo <= A;
            if (start) begin
                r_pend    <= w_result;
                r_pend_we <= w_write;
                r_cnt     <= w_is_div ? 4'd10 : 4'd5;
            end
        end else begin
            r_cnt <= r_cnt - 4'd1;
            if ((r_cnt == 4'd1) && r_pend_we) {r_hi, r_lo} <= r_pend;
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (MDUOp == c_OP_MTHI) r_hi <= A;
            if (MDUOp == c_OP_MTLO) r_lo <= A;
            if (w_write) {r_hi, r_lo} <= w_result;
        end
    end
`endif

endmodule
`default_nettype wire
